timer_arbiter: RTL and testbench
================================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 SHALL have parameter CW, default 4, giving the width of each requester's interval counter and length field.
REQ-002 SHALL support exactly four requesters, indexed 0..3; this count is fixed and not parameterised.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 req_i  input  4  level request per requester, bit n = requester n.
REQ-006 len_i  input  4*CW  interval length per requester, requester n in bits [n*CW +: CW].
REQ-007 gnt_o  output  4  one-hot grant; all zero when no requester owns the counter.
REQ-008 done_o  output  4  one-cycle completion pulse to the granted requester.
REQ-009 busy_o  output  1  high whenever gnt_o is non-zero.
REQ-010 count_o  output  CW  current value of the shared down-counter.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE: when req_i is non-zero, SHALL select a winner, load the counter with that winner's len_i, set gnt_o one-hot to the winner and enter RUN on the next edge. If req_i is zero, stay in IDLE.
REQ-013 Arbitration SHALL be round-robin. The search starts at (ptr+1) mod 4 and proceeds upward with wrap, where ptr is the index of the last granted requester.
REQ-014 ptr SHALL update to the winner's index on every grant, whether that grant completes or aborts.
REQ-015 len_i SHALL be sampled only in the grant cycle; later changes to len_i SHALL NOT affect the running interval.
REQ-016 RUN: while count_o is non-zero, count_o SHALL decrement by 1 per cycle. When count_o is 0, the FSM SHALL enter DONE on the next edge.
REQ-017 RUN therefore lasts len+1 cycles. len=0 gives exactly one RUN cycle.
REQ-018 Counter arithmetic SHALL be unsigned CW-bit. The counter SHALL never wrap below 0.
REQ-019 DONE: done_o SHALL be high for exactly one cycle on the granted bit, with gnt_o still held. The FSM SHALL return to IDLE on the next edge and clear gnt_o.
REQ-020 Abort: if the granted requester's req_i bit is low during any RUN cycle, the FSM SHALL go to IDLE on the next edge, clear gnt_o, emit no done_o and force count_o to 0.
REQ-021 req_i bits of non-granted requesters SHALL be ignored during RUN and DONE; there is no pre-emption.
REQ-022 A requester holding req_i high through DONE SHALL compete again in the following IDLE cycle under normal round-robin order.
REQ-023 Minimum gap: a new grant SHALL appear no earlier than 2 cycles after a done_o pulse, because IDLE is always visited for 1 cycle.
REQ-024 count_o SHALL hold 0 in IDLE and DONE.
REQ-025 Outputs SHALL be driven from registers only, with no combinational path from req_i or len_i to any output.

Reset
REQ-026 rst high SHALL force the FSM to IDLE, gnt_o=0, done_o=0, busy_o=0, count_o=0 and ptr=3, so requester 0 has first priority.
REQ-027 rst SHALL take priority over every other event, including mid-RUN and during DONE. No done_o SHALL be emitted for an interval cut short by reset.
REQ-028 On the first cycle after rst deasserts, the block SHALL be in IDLE and arbitration SHALL proceed normally.

Verification
REQ-029 Single request, basic interval: after reset, req_i=0001, len0=3.
- gnt_o=0001 from cycle 1.
- count_o sequence 3,2,1,0.
- done_o=0001 in cycle 5.
- gnt_o=0 in cycle 6.
REQ-030 Zero length: req_i=0010, len1=0.
- One RUN cycle with count_o=0.
- done_o=0010 in the next cycle.
REQ-031 Round-robin fairness: req_i=1111 held constant, all len=1.
- Grant order is 0,1,2,3,0.
- A done_o pulse accompanies each grant.
- A 1-cycle IDLE gap occurs between grants.
REQ-032 Abort: requester 2 granted with len2=7; req_i[2] dropped when count_o=4.
- Next cycle: IDLE, gnt_o=0, count_o=0.
- No done_o is emitted.
- ptr=2, so requester 3 has next priority.
REQ-033 Reset during RUN: rst asserted for 1 cycle while count_o=5.
- All outputs are 0 on the next cycle.
- With req_i=1111, the first grant after reset goes to requester 0.
REQ-034 Mid-interval len_i change: len_i changes during RUN.
- The countdown is unaffected.
- Non-granted req_i toggling during RUN has no effect on gnt_o.

Source files
------------

// File: rtl/timer_arbiter_if.sv
// Bus bundle for timer_arbiter: request/length inputs and grant/status outputs.
interface timer_arbiter_if #(
  parameter int unsigned CW = 4
);
  logic [3:0]      req_i;
  logic [4*CW-1:0] len_i;
  logic [3:0]      gnt_o;
  logic [3:0]      done_o;
  logic            busy_o;
  logic [CW-1:0]   count_o;

  // Requester side: drives requests and lengths, observes grant status.
  modport master (
    output req_i,
    output len_i,
    input  gnt_o,
    input  done_o,
    input  busy_o,
    input  count_o
  );

  // Arbiter side.
  modport slave (
    input  req_i,
    input  len_i,
    output gnt_o,
    output done_o,
    output busy_o,
    output count_o
  );
endinterface

// File: rtl/timer_arbiter.sv
// Four-requester round-robin arbiter sharing one down-counter.
// A winner owns the counter for len+1 RUN cycles, then gets a one-cycle
// done pulse; dropping its request mid-run aborts without a done pulse.
module timer_arbiter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  timer_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    gnt_q,   gnt_d;
  logic [3:0]    done_q,  done_d;
  logic          busy_q,  busy_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    ptr_q,   ptr_d;

  logic          win_vld;
  logic [1:0]    win_idx;
  logic [CW-1:0] win_len;
  logic          own_req;

  // Round-robin search: candidates ptr+1, ptr+2, ptr+3, then ptr itself.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!win_vld && bus.req_i[2'(ptr_q + 2'(i))]) begin
        win_vld = 1'b1;
        win_idx = 2'(ptr_q + 2'(i));
      end
    end
  end

  // Winner's length and the owner's live request bit.
  always_comb begin
    win_len = bus.len_i[win_idx*CW +: CW];
    own_req = |(bus.req_i & gnt_q);
  end

  // State register; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort is checked before completion in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (win_vld) state_d = RUN;
      end
      RUN: begin
        if (!own_req)            state_d = IDLE;
        else if (count_q == '0)  state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs and arbitration pointer for the next cycle.
  always_comb begin
    gnt_d   = gnt_q;
    done_d  = '0;
    count_d = count_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        count_d = '0;
        if (win_vld) begin
          gnt_d   = 4'b0001 << win_idx;
          count_d = win_len;
          ptr_d   = win_idx;
        end
      end
      RUN: begin
        if (!own_req) begin
          gnt_d   = '0;
          count_d = '0;
        end else if (count_q == '0) begin
          done_d  = gnt_q;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      DONE: begin
        gnt_d   = '0;
        count_d = '0;
      end
      default: begin
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
    busy_d = |gnt_d;
  end

  // Datapath registers; ptr resets to 3 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      ptr_q   <= 2'd3;
    end else begin
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt_o   = gnt_q;
  assign bus.done_o  = done_q;
  assign bus.busy_o  = busy_q;
  assign bus.count_o = count_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: a timeline model predicts each cycle's
// outputs, a monitor pops and compares one prediction per clock.
module tb_timer_arbiter;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  timer_arbiter_if #(.CW(CW)) bus();
  timer_arbiter #(.CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0]    gnt;
    logic [3:0]    done;
    logic          busy;
    logic [CW-1:0] count;
  } exp_t;

  exp_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int exp_dones   = 0;
  int seen_dones  = 0;

  // Model: owner index (-1 none), elapsed cycles since grant, sampled length.
  int m_own = -1;
  int m_k   = 0;
  int m_len = 0;
  int m_ptr = 3;

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    if (m_own >= 0) begin
      e.gnt  = 4'(1 << m_own);
      e.busy = 1'b1;
      if (m_k <= m_len) begin
        e.count = CW'(m_len - m_k);
      end else begin
        e.done = e.gnt;
      end
    end
    return e;
  endfunction

  function automatic void model_step(input logic r, input logic [3:0] req,
                                     input logic [4*CW-1:0] len);
    if (r) begin
      m_own = -1;
      m_ptr = 3;
    end else if (m_own < 0) begin
      if (req != 4'b0) begin
        for (int i = 1; i <= 4; i++) begin
          if (m_own < 0 && req[(m_ptr + i) % 4]) m_own = (m_ptr + i) % 4;
        end
        m_ptr = m_own;
        m_len = int'(len[m_own*CW +: CW]);
        m_k   = 0;
      end
    end else if (m_k <= m_len) begin
      if (!req[m_own]) m_own = -1;
      else begin
        m_k++;
        if (m_k == m_len + 1) exp_dones++;
      end
    end else begin
      m_own = -1;
    end
  endfunction

  function automatic logic [4*CW-1:0] lens(input int a, input int b,
                                           input int c, input int d);
    return {CW'(d), CW'(c), CW'(b), CW'(a)};
  endfunction

  task automatic drive(input logic r, input logic [3:0] req,
                       input logic [4*CW-1:0] len);
    rst        = r;
    bus.req_i  = req;
    bus.len_i  = len;
    model_step(r, req, len);
    exp_q.push_back(model_out());
  endtask

  task automatic cyc(input logic r, input logic [3:0] req,
                     input logic [4*CW-1:0] len);
    @(negedge clk);
    drive(r, req, len);
  endtask

  // Monitor: one comparison per clock, sampled just after the rising edge.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (bus.done_o != 4'b0) seen_dones++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got.gnt   = bus.gnt_o;
        got.done  = bus.done_o;
        got.busy  = bus.busy_o;
        got.count = bus.count_o;
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got gnt=%b done=%b busy=%b count=%0d required gnt=%b done=%b busy=%b count=%0d",
                   $time, got.gnt, got.done, got.busy, got.count,
                   e.gnt, e.done, e.busy, e.count);
        end
      end
    end
  end

  initial begin
    logic [3:0]      rq;
    logic [4*CW-1:0] ln;
    drive(1'b1, 4'b0, '0);
    cyc(1'b1, 4'b0, '0);

    // Single request, len0=3.
    repeat (7) cyc(1'b0, 4'b0001, lens(3, 0, 0, 0));
    repeat (2) cyc(1'b0, 4'b0000, '0);

    // Zero length on requester 1.
    repeat (4) cyc(1'b0, 4'b0010, lens(0, 0, 0, 0));
    repeat (2) cyc(1'b0, 4'b0000, '0);

    // Round-robin, all requesting with len=1.
    repeat (18) cyc(1'b0, 4'b1111, lens(1, 1, 1, 1));
    repeat (2) cyc(1'b0, 4'b0000, '0);

    // Abort: requester 2, len 7, drop when count reaches 4; 3 should win next.
    repeat (4) cyc(1'b0, 4'b0100, lens(2, 2, 7, 2));
    repeat (8) cyc(1'b0, 4'b1011, lens(2, 2, 7, 2));
    repeat (2) cyc(1'b0, 4'b0000, '0);

    // Reset while count is 5, then all request: requester 0 first.
    repeat (4) cyc(1'b0, 4'b0010, lens(3, 8, 3, 3));
    cyc(1'b1, 4'b0010, lens(3, 8, 3, 3));
    repeat (12) cyc(1'b0, 4'b1111, lens(2, 2, 2, 2));
    repeat (2) cyc(1'b0, 4'b0000, '0);

    // Length and foreign requests change mid-interval.
    cyc(1'b0, 4'b0001, lens(6, 0, 0, 0));
    repeat (9) cyc(1'b0, {3'($urandom), 1'b1}, 16'($urandom));
    repeat (2) cyc(1'b0, 4'b0000, '0);

    // Random traffic with sticky requests and occasional reset.
    rq = 4'b0;
    ln = lens(1, 2, 3, 4);
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      end
      if ($urandom_range(0, 3) == 0) ln = 16'($urandom);
      cyc(($urandom_range(0, 99) == 0), rq, ln);
    end
    repeat (2) cyc(1'b0, 4'b0000, '0);

    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    vectors++;
    if (seen_dones != exp_dones) begin
      miscompares++;
      $display("FAIL done_count got %0d required %0d", seen_dones, exp_dones);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
